hex_display_scanner: RTL and testbench
======================================

Name: hex_display_scanner

Overview:
- Upstream neighbour of the hex-to-seven-segment decoder.
- Holds the 16-bit half-precision adder result and time-multiplexes its four hex nibbles onto one shared decoder.
- Drives active-low digit anodes on the 4-digit board display.
- Takes a load strobe from the adder's result path and swaps in new values only at frame boundaries, so digits are never torn.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is lit; legal range 1..2^20.
- NUM_DIGITS, 4: digits scanned; fixed at 4, one per nibble of the 16-bit result.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  16  adder result (sign/exponent/mantissa bits 15:0).
- load  in  1  single-cycle strobe; captures value.
- nibble  out  4  nibble for the decoder inputs {w,x,y,z}; bit 3 = w.
- an  out  4  digit anodes, active-low; an[0] = rightmost digit.
- blank  out  1  high when the current slot is suppressed (see Optional Feature).
- frame_done  out  1  one-cycle pulse when digit 3's slot ends.
- pending  out  1  high while a loaded value waits for the next frame boundary.

Behaviour:
- Reset is asynchronous, active-high. Outputs while reset is high and on release:
  - tick counter = 0, digit index = 0.
  - shown = 16'h0000, pend_val = 16'h0000, pending = 0.
  - an = 4'b1110, nibble = 4'h0, blank = 0, frame_done = 0.
- Reset mid-frame discards any pending value and the shown value.
- Tick counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - The wrap cycle is the "slot end".
  - REFRESH_DIV = 1: every cycle is a slot end.
- Digit index (2-bit):
  - Advances 0→1→2→3→0 on each slot end.
  - The 3→0 transition is the frame boundary; frame_done pulses in that same cycle.
- Digit mapping: digit i shows shown[4i+3:4i].
  - nibble = that nibble.
  - an = all ones with bit i low.
- nibble, an and blank depend only on registered state; no combinational path from value or load.
- load high:
  - pend_val <= value, pending <= 1.
  - A later load before the boundary overwrites pend_val (last load wins).
- At the frame boundary with pending = 1:
  - shown <= pend_val, pending <= 0.
  - The new value appears from digit 0 of the next frame.
- load in the same cycle as the boundary:
  - The boundary transfers the pre-existing pend_val, if any.
  - The new value lands in pend_val with pending = 1 and shows one frame later.
- Display latency from load is 1 to (4·REFRESH_DIV + 1) cycles.
- No backpressure: load is always accepted.

Optional Feature:
- Macro: HEX_DISPLAY_LZ_BLANK_EN.
- Defined, during slot i (i = 1..3):
  - If shown[15:4i] == 0, blank = 1 and an = 4'b1111; nibble keeps its normal value.
  - Digit 0 is never blanked, so 16'h0000 shows a single "0".
  - Blank decisions use shown only, never pend_val.
- Undefined: blank is tied to 0 and all four digits always light.

Decomposition:
- Package display_pkg:
  - NUM_DIGITS = 4.
  - typedef digit_idx_t (logic [1:0]).
  - typedef nibble_t (logic [3:0]).
  - Function anode_for(digit_idx_t), returning the active-low one-cold pattern.
- Sub-module refresh_tick_gen:
  - Parameter REFRESH_DIV.
  - Ports clk, reset, tick.
  - Contains the tick counter; the scanner instantiates it once.
- Digit index, shadow registers and blank logic stay in hex_display_scanner.

Test Plan (REFRESH_DIV = 4):
- Reset: assert reset mid-scan → an = 4'b1110, nibble = 0, pending = 0 immediately, no clock needed. Release → digit 0 held 4 cycles, then an = 4'b1101.
- Scan: load 16'h3C00 (half 1.0) at frame start → pending = 1 until frame_done. Next frame shows nibbles 0,0,C,3 on an 1110,1101,1011,0111, 4 cycles each.
- Last load wins: load 16'h1234 then 16'hABCD within one frame → next frame shows D,C,B,A; 16'h1234 never appears.
- Load at boundary: load 16'h5555 in the frame_done cycle while 16'h7777 is pending → next frame shows 7s, frame after shows 5s.
- REFRESH_DIV = 1 build: digit index advances every cycle and frame_done pulses every 4th cycle.
- LZ blank (macro defined): shown = 16'h000F → slots 1–3 give blank = 1, an = 4'b1111; slot 0 gives nibble = F. shown = 16'h0000 → digit 0 lights "0". Macro undefined → blank stays 0 throughout.

Source files
------------

// File: rtl/hex_display_scanner_pkg.sv
// Shared types and anode helper for the hex display scanner slice.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] nibble_t;

    // Active-low one-cold anode pattern for the given digit slot.
    function automatic logic [3:0] anode_for(digit_idx_t idx);
        logic [3:0] a;
        a      = 4'b1111;
        a[idx] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load/value bus into the scanner and the multiplexed display outputs.
// Latency: wires only.
// Backpressure: none; load is always accepted.
interface hex_display_scanner_if;
    import display_pkg::*;

    logic [15:0] value;
    logic        load;
    nibble_t     nibble;
    logic [3:0]  an;
    logic        blank;
    logic        frame_done;
    logic        pending;

    modport master (
        output value, load,
        input  nibble, an, blank, frame_done, pending
    );

    modport slave (
        input  value, load,
        output nibble, an, blank, frame_done, pending
    );

endinterface

// File: rtl/hex_display_scanner_refresh_tick_gen.sv
// Slot timer: asserts tick on the last cycle of every REFRESH_DIV-cycle slot.
// Latency: tick is decoded from the registered count, no input path.
// Backpressure: none; free-running.
module refresh_tick_gen #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // One bit minimum so REFRESH_DIV = 1 still yields a legal counter.
    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Scans a 16-bit result onto a 4-digit display; new values swap in at frame boundaries only.
// Latency: outputs are registered-state only; load shows after 1..4*REFRESH_DIV+1 cycles.
// Backpressure: none. Optional leading-zero blanking via HEX_DISPLAY_LZ_BLANK_EN.
module hex_display_scanner
    import display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    hex_display_scanner_if.slave  bus
);

    digit_idx_t  digit_idx;
    logic [15:0] shown;
    logic [15:0] pend_val;
    logic        pending_q;
    logic        tick;
    logic        boundary;
    logic        lz_blank;

    refresh_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary = tick && (digit_idx == 2'd3);

    // A load coinciding with the boundary lands in pend_val after the old
    // pending value has already moved to shown, so it waits one more frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_idx <= '0;
            shown     <= '0;
            pend_val  <= '0;
            pending_q <= 1'b0;
        end else begin
            if (tick) begin
                digit_idx <= digit_idx + 2'd1;
            end
            if (boundary && pending_q) begin
                shown <= pend_val;
            end
            if (bus.load) begin
                pend_val  <= bus.value;
                pending_q <= 1'b1;
            end else if (boundary) begin
                pending_q <= 1'b0;
            end
        end
    end

`ifdef HEX_DISPLAY_LZ_BLANK_EN
    // Digit 0 always lights so an all-zero result still reads "0".
    always_comb begin
        lz_blank = 1'b0;
        case (digit_idx)
            2'd1:    lz_blank = (shown[15:4]  == 12'h000);
            2'd2:    lz_blank = (shown[15:8]  == 8'h00);
            2'd3:    lz_blank = (shown[15:12] == 4'h0);
            default: lz_blank = 1'b0;
        endcase
    end
`else
    assign lz_blank = 1'b0;
`endif

    assign bus.nibble     = shown[{digit_idx, 2'b00} +: 4];
    assign bus.an         = lz_blank ? 4'b1111 : anode_for(digit_idx);
    assign bus.blank      = lz_blank;
    assign bus.frame_done = boundary;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner: REFRESH_DIV=4 main instance plus a REFRESH_DIV=1 instance.
module tb_hex_display_scanner;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    hex_display_scanner_if bus();
    hex_display_scanner_if bus_f();

    hex_display_scanner #(.REFRESH_DIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    hex_display_scanner #(.REFRESH_DIV(1)) u_fast (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef HEX_DISPLAY_LZ_BLANK_EN
    localparam logic [3:0] AN_D1_ZERO = 4'b1111;
`else
    localparam logic [3:0] AN_D1_ZERO = 4'b1101;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned in the frame_done cycle of the main instance.
    task automatic wait_frame_done();
        int i;
        for (i = 0; i < 40; i++) begin
            if (bus.frame_done === 1'b1) break;
            step();
        end
        n_checks++;
        if (bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_done_timeout: got %b expected 1", bus.frame_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.value = '0; bus.load = 1'b0;
        bus_f.value = '0; bus_f.load = 1'b0;
        step(); step();
        n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL rst_an: got %b expected 1110", bus.an); end
        n_checks++; if (bus.nibble !== 4'h0) begin n_fail++; $display("FAIL rst_nibble: got %h expected 0", bus.nibble); end
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL rst_pending: got %b expected 0", bus.pending); end
        n_checks++; if (bus.blank !== 1'b0) begin n_fail++; $display("FAIL rst_blank: got %b expected 0", bus.blank); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", bus.frame_done); end
        reset = 1'b0;
        bus.value = 16'h1234; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step(); step(); step(); step();
        n_checks++; if (bus.an !== AN_D1_ZERO) begin n_fail++; $display("FAIL pre_reset_an: got %b expected %b", bus.an, AN_D1_ZERO); end
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL pre_reset_pending: got %b expected 1", bus.pending); end
        reset = 1'b1;
        #2;
        n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL async_rst_an: got %b expected 1110", bus.an); end
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL async_rst_pending: got %b expected 0", bus.pending); end
        n_checks++; if (bus.nibble !== 4'h0) begin n_fail++; $display("FAIL async_rst_nibble: got %h expected 0", bus.nibble); end
        step(); step();
        reset = 1'b0;
        n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL release_an0: got %b expected 1110", bus.an); end
        for (int k = 1; k < 4; k++) begin
            step();
            n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL hold_digit0_c%0d: got %b expected 1110", k, bus.an); end
        end
        step();
        n_checks++; if (bus.an !== AN_D1_ZERO) begin n_fail++; $display("FAIL advance_digit1: got %b expected %b", bus.an, AN_D1_ZERO); end
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL pending_discarded: got %b expected 0", bus.pending); end
    endtask

    task automatic test_scan();
        logic [15:0] exp_v;
        logic [3:0]  exp_an;
        exp_v = 16'h3C00;
        wait_frame_done();
        step();
        bus.value = exp_v; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL scan_pending_set: got %b expected 1", bus.pending); end
        wait_frame_done();
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL scan_pending_at_boundary: got %b expected 1", bus.pending); end
        step();
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL scan_pending_cleared: got %b expected 0", bus.pending); end
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                exp_an = 4'b1111; exp_an[d] = 1'b0;
                n_checks++; if (bus.nibble !== exp_v[4*d +: 4]) begin n_fail++; $display("FAIL scan_nibble_d%0d_c%0d: got %h expected %h", d, c, bus.nibble, exp_v[4*d +: 4]); end
                n_checks++; if (bus.an !== exp_an) begin n_fail++; $display("FAIL scan_an_d%0d_c%0d: got %b expected %b", d, c, bus.an, exp_an); end
                n_checks++; if (bus.frame_done !== (d == 3 && c == 3)) begin n_fail++; $display("FAIL scan_frame_done_d%0d_c%0d: got %b", d, c, bus.frame_done); end
                step();
            end
        end
    endtask

    task automatic test_last_load_wins();
        logic [15:0] exp_v;
        exp_v = 16'hABCD;
        bus.value = 16'h1234; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        bus.value = exp_v; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_frame_done();
        step();
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL llw_pending: got %b expected 0", bus.pending); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (bus.nibble !== exp_v[4*d +: 4]) begin n_fail++; $display("FAIL llw_nibble_d%0d: got %h expected %h", d, bus.nibble, exp_v[4*d +: 4]); end
            repeat (4) step();
        end
    endtask

    task automatic test_load_at_boundary();
        bus.value = 16'h7777; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_frame_done();
        bus.value = 16'h5555; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        n_checks++; if (bus.pending !== 1'b1) begin n_fail++; $display("FAIL lab_pending_kept: got %b expected 1", bus.pending); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (bus.nibble !== 4'h7) begin n_fail++; $display("FAIL lab_first_frame_d%0d: got %h expected 7", d, bus.nibble); end
            repeat (4) step();
        end
        n_checks++; if (bus.pending !== 1'b0) begin n_fail++; $display("FAIL lab_pending_cleared: got %b expected 0", bus.pending); end
        for (int d = 0; d < 4; d++) begin
            n_checks++; if (bus.nibble !== 4'h5) begin n_fail++; $display("FAIL lab_second_frame_d%0d: got %h expected 5", d, bus.nibble); end
            repeat (4) step();
        end
    endtask

    task automatic test_fast_refresh();
        logic [15:0] exp_v;
        logic [3:0]  exp_an;
        int          fd_count;
        exp_v = 16'h4321;
        bus_f.value = exp_v; bus_f.load = 1'b1;
        step();
        bus_f.load = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 8; i++) begin
            if (bus_f.frame_done === 1'b1) break;
            step();
        end
        n_checks++; if (bus_f.frame_done !== 1'b1) begin n_fail++; $display("FAIL fast_frame_done_timeout: got %b expected 1", bus_f.frame_done); end
        step();
        fd_count = 0;
        for (int k = 0; k < 12; k++) begin
            exp_an = 4'b1111; exp_an[k % 4] = 1'b0;
            n_checks++; if (bus_f.nibble !== exp_v[4*(k%4) +: 4]) begin n_fail++; $display("FAIL fast_nibble_k%0d: got %h expected %h", k, bus_f.nibble, exp_v[4*(k%4) +: 4]); end
            n_checks++; if (bus_f.an !== exp_an) begin n_fail++; $display("FAIL fast_an_k%0d: got %b expected %b", k, bus_f.an, exp_an); end
            if (bus_f.frame_done === 1'b1) fd_count++;
            step();
        end
        n_checks++; if (fd_count !== 3) begin n_fail++; $display("FAIL fast_frame_done_count: got %0d expected 3", fd_count); end
    endtask

    task automatic test_lz_blank();
        logic [3:0] exp_an;
        logic       exp_blank;
        bus.value = 16'h000F; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_frame_done();
        step();
        for (int d = 0; d < 4; d++) begin
            exp_an = 4'b1111; exp_an[d] = 1'b0;
            exp_blank = 1'b0;
`ifdef HEX_DISPLAY_LZ_BLANK_EN
            if (d != 0) begin exp_an = 4'b1111; exp_blank = 1'b1; end
`endif
            n_checks++; if (bus.blank !== exp_blank) begin n_fail++; $display("FAIL lz_000f_blank_d%0d: got %b expected %b", d, bus.blank, exp_blank); end
            n_checks++; if (bus.an !== exp_an) begin n_fail++; $display("FAIL lz_000f_an_d%0d: got %b expected %b", d, bus.an, exp_an); end
            n_checks++; if (bus.nibble !== ((d == 0) ? 4'hF : 4'h0)) begin n_fail++; $display("FAIL lz_000f_nibble_d%0d: got %h", d, bus.nibble); end
            repeat (4) step();
        end
        bus.value = 16'h0000; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        wait_frame_done();
        step();
        n_checks++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL lz_zero_d0_an: got %b expected 1110", bus.an); end
        n_checks++; if (bus.blank !== 1'b0) begin n_fail++; $display("FAIL lz_zero_d0_blank: got %b expected 0", bus.blank); end
        n_checks++; if (bus.nibble !== 4'h0) begin n_fail++; $display("FAIL lz_zero_d0_nibble: got %h expected 0", bus.nibble); end
        repeat (4) step();
        n_checks++; if (bus.an !== AN_D1_ZERO) begin n_fail++; $display("FAIL lz_zero_d1_an: got %b expected %b", bus.an, AN_D1_ZERO); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_scan();
        test_last_load_wins();
        test_load_at_boundary();
        test_fast_refresh();
        test_lz_blank();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
